call_stack: RTL and testbench
=============================

Name: call_stack

Overview:
- Hardware return-address stack that services the controller's push, pop and RET strobes.
- On a subroutine call, the datapath pushes the return PC. On RET, the stack supplies the saved PC to the PC-source mux and then discards it.
- Sits beside the PC register in the single-cycle datapath. It is the responder to the controller's stack-control outputs.

Parameters:
- DEPTH, 8, number of return-address entries; must be a power of two, at least 2.
- ADDR_W, 12, width of a PC / return address in bits.
- CNT_W, 4, pointer/count width; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- push  input  1  from controller: store pcIn on this edge.
- pop  input  1  from controller: discard top entry on this edge.
- pcIn  input  ADDR_W  return address to store (PC+1 from datapath).
- top  output  ADDR_W  current top entry; combinational read; 0 when empty.
- count  output  CNT_W  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (rst=1 at an edge): sp=0 and overflow=underflow=0. Storage array is not cleared. After that edge: top=0, count=0, empty=1, full=0. Reset has priority over push/pop in the same cycle.
- Pointer: sp (CNT_W bits) equals count. Entry i is valid for i<sp. top = mem[sp-1] when sp!=0, else 0.
- Read latency 0: top reflects state after the previous edge. The controller's RET cycle samples top in the same cycle it asserts pop.
- Write latency 1: an entry pushed at edge N appears on top after edge N.
- push=1, pop=0:
  - not full: mem[sp] <= pcIn, sp <= sp+1.
  - full: no change to mem or sp, overflow <= 1.
- pop=1, push=0:
  - not empty: sp <= sp-1 (entry contents untouched).
  - empty: no change, underflow <= 1.
- push=1, pop=1:
  - not empty: replace in place, mem[sp-1] <= pcIn, sp unchanged. This is legal when full; no overflow.
  - empty: push performed (mem[0] <= pcIn, sp <= 1) and underflow <= 1.
- Idle (both 0): state holds.
- Sticky flags clear only on rst.
- No wrap-around: sp saturates at 0 and DEPTH. The array index is sp[CNT_W-2:0] for writes and (sp-1)[CNT_W-2:0] for reads.
- Arithmetic: sp±1 in CNT_W bits with no carry out by construction; pcIn is stored unmodified.
- X-safety: push/pop are treated as 0 while rst=1.

Decomposition:
- Shared package holds ADDR_W and DEPTH defaults, shared with the PC/datapath modules.
- Package also holds a localparam for the stack-op encoding {NONE, PUSH, POP, REPLACE}, derived from {push,pop}.
- One natural sub-module, stack_regfile: DEPTH×ADDR_W array with one synchronous write port and one asynchronous read port.
- Pointer, flag and next-state logic stay in call_stack.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then release. Required: top=0, count=0, empty=1, full=0, overflow=0, underflow=0.
- LIFO order: push 12'h010, 12'h020, 12'h030 on consecutive edges. Required: top=030, count=3. Pop 3 times; top reads 030, 020, 010, then 0, with empty=1 after the 3rd pop.
- Full/overflow: push 8 values 12'h001..12'h008. Required: full=1, top=008. 9th push of 12'hFFF: top still 008, count=8, overflow=1.
- Underflow and simultaneous ops: pop on empty gives underflow=1, count=0. Push&pop with pcIn=12'h0AB on empty gives count=1, top=0AB. Push&pop with pcIn=12'h0CD gives count=1, top=0CD.
- Reset mid-operation: with count=5 and overflow=1, assert rst together with push of 12'h123. Required next cycle: count=0, top=0, flags 0, and the push is ignored.
- RET timing: with top=12'h040, assert pop with an external mux select. Required: 040 is visible in the pop cycle; after the edge, top shows the prior entry.

Source files
------------

// File: rtl/call_stack_pkg.sv
// rtl/call_stack_pkg.sv - shared return-stack defaults and stack-op encoding
package call_stack_pkg;

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_ADDR_W = 12;

  // Stack operation, encoded directly as {push, pop}
  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_t;

  // Strobes are forced to NONE while reset is held so X on push/pop is harmless
  function automatic stack_op_t decode_op(input logic rst, input logic push, input logic pop);
    if (rst) begin
      return OP_NONE;
    end
    return stack_op_t'({push, pop});
  endfunction

endpackage

// File: rtl/call_stack_if.sv
// rtl/call_stack_if.sv - controller-to-return-stack strobe and status bundle
interface call_stack_if #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 4
);

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] pcIn;
  logic [ADDR_W-1:0] top;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  // Controller side drives the strobes and reads status
  modport master (
    output push, pop, pcIn,
    input  top, count, empty, full, overflow, underflow
  );

  // Stack side services the strobes
  modport slave (
    input  push, pop, pcIn,
    output top, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/call_stack_regfile.sv
// rtl/call_stack_regfile.sv - return-address storage, one sync write and one async read port
module stack_regfile #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 12,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  // Contents are deliberately not reset; the pointer alone defines validity
  logic [ADDR_W-1:0] mem [DEPTH];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// rtl/call_stack.sv - hardware return-address stack beside the PC register
module call_stack
  import call_stack_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          rst,
  call_stack_if.slave  bus
);

  localparam int IDX_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0]  sp;
  logic [CNT_W-1:0]  sp_next;
  logic [CNT_W-1:0]  sp_m1;
  logic              overflow_q;
  logic              overflow_next;
  logic              underflow_q;
  logic              underflow_next;
  logic              is_empty;
  logic              is_full;
  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [ADDR_W-1:0] rdata;
  stack_op_t         op;

  assign op       = decode_op(rst, bus.push, bus.pop);
  assign is_empty = (sp == '0);
  assign is_full  = (sp == DEPTH_C);
  assign sp_m1    = sp - ONE_C;

  // Pointer, sticky-flag and write-port next state from the decoded op
  always_comb begin
    sp_next        = sp;
    overflow_next  = overflow_q;
    underflow_next = underflow_q;
    we             = 1'b0;
    waddr          = sp[IDX_W-1:0];
    unique case (op)
      OP_PUSH: begin
        if (is_full) begin
          overflow_next = 1'b1;
        end else begin
          we      = 1'b1;
          sp_next = sp + ONE_C;
        end
      end
      OP_POP: begin
        if (is_empty) begin
          underflow_next = 1'b1;
        end else begin
          sp_next = sp_m1;
        end
      end
      OP_REPLACE: begin
        // Replace in place is legal even when full; on empty it degrades to a push
        we = 1'b1;
        if (is_empty) begin
          waddr          = '0;
          sp_next        = ONE_C;
          underflow_next = 1'b1;
        end else begin
          waddr = sp_m1[IDX_W-1:0];
        end
      end
      default: begin
      end
    endcase
  end

  // State register; reset wins over any strobe in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sp          <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp          <= sp_next;
      overflow_q  <= overflow_next;
      underflow_q <= underflow_next;
    end
  end

  stack_regfile #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.pcIn),
    .raddr (sp_m1[IDX_W-1:0]),
    .rdata (rdata)
  );

  // Zero-latency top so the RET cycle sees the entry it is popping
  assign bus.top       = is_empty ? '0 : rdata;
  assign bus.count     = sp;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_call_stack.sv
// tb/tb_call_stack.sv - self-checking bench for call_stack
module tb_call_stack;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst;

  call_stack_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  call_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a queue whose back is the top of stack
  logic [ADDR_W-1:0] stk[$];
  logic              m_ovf = 1'b0;
  logic              m_unf = 1'b0;
  bit                started = 1'b0;
  int                checks = 0;
  int                failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [ADDR_W-1:0] m_top();
    return (stk.size() == 0) ? '0 : stk[stk.size()-1];
  endfunction

  function automatic void model_edge(input logic r, input logic p, input logic q, input logic [ADDR_W-1:0] pc);
    if (r) begin
      stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (p && q) begin
      if (stk.size() == 0) begin
        stk.push_back(pc);
        m_unf = 1'b1;
      end else begin
        stk[stk.size()-1] = pc;
      end
    end else if (p) begin
      if (stk.size() == DEPTH) m_ovf = 1'b1;
      else stk.push_back(pc);
    end else if (q) begin
      if (stk.size() == 0) m_unf = 1'b1;
      else void'(stk.pop_back());
    end
  endfunction

  // Apply one cycle of stimulus, advance the model after the edge, return at negedge
  task automatic step(input logic r, input logic p, input logic q, input logic [ADDR_W-1:0] pc);
    rst      = r;
    bus.push = p;
    bus.pop  = q;
    bus.pcIn = pc;
    @(posedge clk);
    #1;
    model_edge(r, p, q, pc);
    @(negedge clk);
  endtask

  // Per-cycle comparison of every status output against the model
  always @(negedge clk) begin
    if (started) begin
      chk("top",       32'(bus.top),       32'(m_top()));
      chk("count",     32'(bus.count),     32'(stk.size()));
      chk("empty",     32'(bus.empty),     32'(stk.size() == 0));
      chk("full",      32'(bus.full),      32'(stk.size() == DEPTH));
      chk("overflow",  32'(bus.overflow),  32'(m_ovf));
      chk("underflow", 32'(bus.underflow), 32'(m_unf));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  logic [ADDR_W-1:0] mux_out;
  logic [ADDR_W-1:0] vals [3];

  initial begin
    vals[0] = 12'h010; vals[1] = 12'h020; vals[2] = 12'h030;
    rst = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.pcIn = '0;
    @(negedge clk);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    started = 1'b1;
    step(0, 0, 0, 0);
    chk("rst_top", 32'(bus.top), 32'h0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);

    // LIFO order
    for (int i = 0; i < 3; i++) step(0, 1, 0, vals[i]);
    chk("lifo_top", 32'(bus.top), 32'h030);
    chk("lifo_count", 32'(bus.count), 32'd3);
    for (int i = 2; i >= 0; i--) begin
      chk("lifo_pop_top", 32'(bus.top), 32'(vals[i]));
      step(0, 0, 1, 0);
    end
    chk("lifo_end_top", 32'(bus.top), 32'h0);
    chk("lifo_end_empty", 32'(bus.empty), 32'd1);

    // Fill and overflow
    for (int i = 1; i <= 8; i++) step(0, 1, 0, ADDR_W'(i));
    chk("full_flag", 32'(bus.full), 32'd1);
    chk("full_top", 32'(bus.top), 32'h008);
    step(0, 1, 0, 12'hFFF);
    chk("ovf_top", 32'(bus.top), 32'h008);
    chk("ovf_count", 32'(bus.count), 32'd8);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    // Replace while full: no new overflow source, top changes, count holds
    step(0, 1, 1, 12'h777);
    chk("repl_full_top", 32'(bus.top), 32'h777);
    chk("repl_full_count", 32'(bus.count), 32'd8);
    step(0, 0, 1, 0);
    chk("below_repl_top", 32'(bus.top), 32'h007);

    // Underflow and simultaneous ops
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("unf_flag", 32'(bus.underflow), 32'd1);
    chk("unf_count", 32'(bus.count), 32'd0);
    step(0, 1, 1, 12'h0AB);
    chk("pp_empty_count", 32'(bus.count), 32'd1);
    chk("pp_empty_top", 32'(bus.top), 32'h0AB);
    step(0, 1, 1, 12'h0CD);
    chk("pp_count", 32'(bus.count), 32'd1);
    chk("pp_top", 32'(bus.top), 32'h0CD);

    // Reset mid-operation with count=5 and overflow set
    step(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, ADDR_W'(12'h100 + i));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    chk("pre_rst_count", 32'(bus.count), 32'd5);
    chk("pre_rst_ovf", 32'(bus.overflow), 32'd1);
    step(1, 1, 0, 12'h123);
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_top", 32'(bus.top), 32'h0);
    chk("mid_rst_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);

    // RET timing: top visible to the PC mux during the pop cycle
    step(0, 1, 0, 12'h050);
    step(0, 1, 0, 12'h040);
    rst = 1'b0; bus.push = 1'b0; bus.pop = 1'b1; bus.pcIn = 12'h200;
    #1;
    mux_out = bus.pop ? bus.top : bus.pcIn;
    chk("ret_mux", 32'(mux_out), 32'h040);
    @(posedge clk);
    #1;
    model_edge(0, 0, 1, 0);
    @(negedge clk);
    chk("ret_after_top", 32'(bus.top), 32'h050);
    step(0, 0, 0, 0);

    started = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
